// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM encodings,
// word geometry and the default load address.
package loader_defs;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECV  = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3,
    ERROR = 3'd4
  } state_t;

  localparam int          BYTES_PER_WORD    = 4;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_0000;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs accepted stream bytes into a 32-bit big-endian word; the first byte
// of each group of four lands in bits [31:24].
module byte_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        push,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        word_full
);
  import loader_defs::*;

  logic [1:0] idx;

  assign word_full = push && (idx == 2'(BYTES_PER_WORD - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      idx  <= '0;
      word <= '0;
    end else if (push) begin
      // ~idx*8+7 gives 31, 23, 15, 7 for byte index 0..3
      word[{~idx, 3'b111} -: 8] <= data;
      idx                       <= idx + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory writer: receives a byte stream, packs it into
// words, writes them from BASE_ADDR upward and holds the core until done.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = loader_defs::DEFAULT_BASE_ADDR,
  parameter int          DEPTH     = 64,
  parameter int          CNT_W     = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  input  logic             byte_last,
  output logic             byte_ready,
  output logic             wr_en,
  output logic [31:0]      wr_addr,
  output logic [31:0]      wr_data,
  output logic [CNT_W-1:0] word_count,
  output logic             cpu_hold,
  output logic             done,
  output logic             err
);
  import loader_defs::*;

  state_t           state, state_nxt;
  logic             last_q, last_nxt;
  logic [31:0]      addr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             accept, at_cap, load_clr, pack_push, word_full;

  assign byte_ready = (state == RECV);
  assign accept     = byte_valid && byte_ready;
  assign at_cap     = (cnt_q == CNT_W'(DEPTH));
  assign load_clr   = start && (state == IDLE || state == DONE || state == ERROR);
  // An overflowing byte is consumed but never reaches the packer.
  assign pack_push  = accept && !at_cap;

  byte_packer u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (load_clr),
    .push      (pack_push),
    .data      (byte_data),
    .word      (wr_data),
    .word_full (word_full)
  );

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    last_nxt  = last_q;
    unique case (state)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_nxt = RECV;
          last_nxt  = 1'b0;
        end
      end
      RECV: begin
        if (accept) begin
          if (at_cap) begin
            state_nxt = ERROR;
          end else if (word_full) begin
            state_nxt = WRITE;
            last_nxt  = byte_last;
          end else if (byte_last) begin
            state_nxt = ERROR;
          end
        end
      end
      WRITE:   state_nxt = last_q ? DONE : RECV;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      last_q <= 1'b0;
      addr_q <= BASE_ADDR;
      cnt_q  <= '0;
    end else begin
      state  <= state_nxt;
      last_q <= last_nxt;
      if (load_clr) begin
        addr_q <= BASE_ADDR;
        cnt_q  <= '0;
      end else if (state == WRITE) begin
        addr_q <= addr_q + 32'd4;
        if (!at_cap) cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign wr_en      = (state == WRITE);
  assign wr_addr    = {addr_q[31:2], 2'b00};
  assign word_count = cnt_q;
  assign cpu_hold   = (state != DONE);
  assign done       = (state == DONE);
  assign err        = (state == ERROR);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: three instances (default, DEPTH=2, relocated
// base) share one stimulus stream; each test checks the relevant instance.
module tb_imem_loader;

  logic       clk = 1'b0;
  logic       rst_n, start, byte_valid, byte_last;
  logic [7:0] byte_data;

  always #5 clk = ~clk;

  logic a_ready, a_wr_en, a_hold, a_done, a_err;
  logic b_ready, b_wr_en, b_hold, b_done, b_err;
  logic c_ready, c_wr_en, c_hold, c_done, c_err;
  logic [31:0] a_wr_addr, a_wr_data, b_wr_addr, b_wr_data, c_wr_addr, c_wr_data;
  logic [6:0]  a_count, b_count, c_count;

  imem_loader dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_last(byte_last), .byte_ready(a_ready),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .word_count(a_count), .cpu_hold(a_hold), .done(a_done), .err(a_err));

  imem_loader #(.DEPTH(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_last(byte_last), .byte_ready(b_ready),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .word_count(b_count), .cpu_hold(b_hold), .done(b_done), .err(b_err));

  imem_loader #(.BASE_ADDR(32'h0040_0000)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_last(byte_last), .byte_ready(c_ready),
    .wr_en(c_wr_en), .wr_addr(c_wr_addr), .wr_data(c_wr_data),
    .word_count(c_count), .cpu_hold(c_hold), .done(c_done), .err(c_err));

  logic [31:0] qa_addr[$], qa_data[$], qb_addr[$], qb_data[$], qc_addr[$], qc_data[$];

  always @(negedge clk) begin
    if (a_wr_en) begin qa_addr.push_back(a_wr_addr); qa_data.push_back(a_wr_data); end
    if (b_wr_en) begin qb_addr.push_back(b_wr_addr); qb_data.push_back(b_wr_data); end
    if (c_wr_en) begin qc_addr.push_back(c_wr_addr); qc_data.push_back(c_wr_data); end
  end

  int checks = 0;
  int errors = 0;
  int sel    = 0;
  logic ready_sel;
  assign ready_sel = (sel == 0) ? a_ready : (sel == 1) ? b_ready : c_ready;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_logs();
    qa_addr.delete(); qa_data.delete();
    qb_addr.delete(); qb_data.delete();
    qc_addr.delete(); qc_data.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    int n;
    byte_valid = 1'b1;
    byte_data  = d;
    byte_last  = l;
    n = 0;
    while (!ready_sel && n < 20) begin tick(1); n++; end
    check("ready wait", {31'd0, ready_sel}, 32'd1);
    tick(1);
    byte_valid = 1'b0;
    byte_last  = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  logic [7:0] prog [8];
  logic       ready_ok;

  initial begin
    prog[0] = 8'h8C; prog[1] = 8'h01; prog[2] = 8'h00; prog[3] = 8'h04;
    prog[4] = 8'hAC; prog[5] = 8'h02; prog[6] = 8'h00; prog[7] = 8'h08;
    start = 1'b0; byte_valid = 1'b0; byte_last = 1'b0; byte_data = 8'h00;
    apply_reset();

    // Reset state
    check("rst ready", {31'd0, a_ready}, 32'd0);
    check("rst wr_en", {31'd0, a_wr_en}, 32'd0);
    check("rst wr_addr", a_wr_addr, 32'h0);
    check("rst wr_data", a_wr_data, 32'h0);
    check("rst count", {25'd0, a_count}, 32'd0);
    check("rst hold", {31'd0, a_hold}, 32'd1);
    check("rst done", {31'd0, a_done}, 32'd0);
    check("rst err", {31'd0, a_err}, 32'd0);

    // Byte offered while idle is not consumed
    byte_valid = 1'b1; byte_data = 8'hEE;
    tick(2);
    byte_valid = 1'b0;
    check("idle ignore", qa_addr.size(), 32'd0);

    // Test 1: two-word program
    sel = 0;
    clear_logs();
    pulse_start();
    for (int i = 0; i < 8; i++) send_byte(prog[i], i == 7);
    tick(2);
    check("t1 nwrites", qa_addr.size(), 32'd2);
    check("t1 addr0", qa_addr[0], 32'h0000_0000);
    check("t1 data0", qa_data[0], 32'h8C01_0004);
    check("t1 addr1", qa_addr[1], 32'h0000_0004);
    check("t1 data1", qa_data[1], 32'hAC02_0008);
    check("t1 count", {25'd0, a_count}, 32'd2);
    check("t1 done", {31'd0, a_done}, 32'd1);
    check("t1 hold", {31'd0, a_hold}, 32'd0);
    check("t1 err", {31'd0, a_err}, 32'd0);
    check("t1c addr0", qc_addr[0], 32'h0040_0000);
    check("t1c addr1", qc_addr[1], 32'h0040_0004);

    // Test 6: reload from DONE at relocated base
    sel = 2;
    clear_logs();
    check("t6 pre done", {31'd0, c_done}, 32'd1);
    check("t6 pre hold", {31'd0, c_hold}, 32'd0);
    pulse_start();
    check("t6 hold rise", {31'd0, c_hold}, 32'd1);
    check("t6 done drop", {31'd0, c_done}, 32'd0);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("t6 start in recv", {31'd0, c_ready}, 32'd1);
    send_byte(8'h12, 1'b0); send_byte(8'h34, 1'b0);
    send_byte(8'h56, 1'b0); send_byte(8'h78, 1'b1);
    tick(2);
    check("t6 nwrites", qc_addr.size(), 32'd1);
    check("t6 addr", qc_addr[0], 32'h0040_0000);
    check("t6 data", qc_data[0], 32'h1234_5678);
    check("t6 count", {25'd0, c_count}, 32'd1);
    check("t6 done", {31'd0, c_done}, 32'd1);

    // Test 2: gaps between bytes
    sel = 0;
    clear_logs();
    pulse_start();
    ready_ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send_byte(prog[i], i == 7);
      if (i % 4 != 3) begin
        for (int g = 0; g < 3; g++) begin
          if (a_ready !== 1'b1) ready_ok = 1'b0;
          tick(1);
        end
      end
    end
    tick(2);
    check("t2 ready held", {31'd0, ready_ok}, 32'd1);
    check("t2 nwrites", qa_addr.size(), 32'd2);
    check("t2 addr0", qa_addr[0], 32'h0000_0000);
    check("t2 data0", qa_data[0], 32'h8C01_0004);
    check("t2 addr1", qa_addr[1], 32'h0000_0004);
    check("t2 data1", qa_data[1], 32'hAC02_0008);
    check("t2 done", {31'd0, a_done}, 32'd1);

    // Test 3: last on byte index 1 of second word
    clear_logs();
    pulse_start();
    for (int i = 0; i < 6; i++) send_byte(prog[i], i == 5);
    tick(2);
    check("t3 nwrites", qa_addr.size(), 32'd1);
    check("t3 data0", qa_data[0], 32'h8C01_0004);
    check("t3 err", {31'd0, a_err}, 32'd1);
    check("t3 hold", {31'd0, a_hold}, 32'd1);
    check("t3 done", {31'd0, a_done}, 32'd0);
    check("t3 ready", {31'd0, a_ready}, 32'd0);

    // Test 5: reset mid-word, then a fresh one-word load
    clear_logs();
    pulse_start();
    check("t5 err clr", {31'd0, a_err}, 32'd0);
    send_byte(8'h8C, 1'b0); send_byte(8'h01, 1'b0);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    check("t5 rst err", {31'd0, a_err}, 32'd0);
    check("t5 rst hold", {31'd0, a_hold}, 32'd1);
    check("t5 rst ready", {31'd0, a_ready}, 32'd0);
    pulse_start();
    send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0); send_byte(8'h44, 1'b1);
    tick(2);
    check("t5 nwrites", qa_addr.size(), 32'd1);
    check("t5 addr", qa_addr[0], 32'h0000_0000);
    check("t5 data", qa_data[0], 32'h1122_3344);
    check("t5 count", {25'd0, a_count}, 32'd1);
    check("t5 done", {31'd0, a_done}, 32'd1);

    // Test 4: DEPTH=2 overflow
    apply_reset();
    sel = 1;
    clear_logs();
    pulse_start();
    for (int i = 1; i <= 9; i++) send_byte(8'(i), 1'b0);
    check("t4 err after 9", {31'd0, b_err}, 32'd1);
    byte_valid = 1'b1;
    for (int i = 10; i <= 12; i++) begin byte_data = 8'(i); tick(1); end
    byte_valid = 1'b0;
    tick(2);
    check("t4 nwrites", qb_addr.size(), 32'd2);
    check("t4 addr0", qb_addr[0], 32'h0000_0000);
    check("t4 data0", qb_data[0], 32'h0102_0304);
    check("t4 addr1", qb_addr[1], 32'h0000_0004);
    check("t4 data1", qb_data[1], 32'h0506_0708);
    check("t4 count sat", {25'd0, b_count}, 32'd2);
    check("t4 err", {31'd0, b_err}, 32'd1);
    check("t4 hold", {31'd0, b_hold}, 32'd1);
    check("t4 done", {31'd0, b_done}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
